sqrt_iter_core: RTL and testbench

Iterative non-restoring integer square root engine. It produces the root Q, the remainder R and the ready flag RDY that the downstream init/hold register stage captures. It takes a 2*WIDTH-bit radicand on a start pulse and retires one root bit per clock. Results sit in output registers until the consumer acknowledges them.

---
 rtl/sqrt_iter_core_if.sv | 21 ++
 rtl/sqrt_iter_core.sv | 119 +++++++++++
 tb/tb_sqrt_iter_core.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_iter_core_if.sv
// Handshake and result bundle for sqrt_iter_core.
// The EXACT result flag exists only when SQRT_EXACT_FLAG_EN is defined.
interface sqrt_iter_core_if #(parameter int WIDTH = 16);
  logic                 clr;
  logic                 start;
  logic [2*WIDTH-1:0]   D;
  logic                 ack;
  logic [WIDTH-1:0]     Q;
  logic [WIDTH:0]       R;
  logic                 RDY;
  logic                 BUSY;
`ifdef SQRT_EXACT_FLAG_EN
  logic                 EXACT;

  modport master (output clr, start, D, ack, input Q, R, RDY, BUSY, EXACT);
  modport slave  (input clr, start, D, ack, output Q, R, RDY, BUSY, EXACT);
`else
  modport master (output clr, start, D, ack, input Q, R, RDY, BUSY);
  modport slave  (input clr, start, D, ack, output Q, R, RDY, BUSY);
`endif
endinterface

// File: rtl/sqrt_iter_core.sv
// Iterative non-restoring integer square root, one root bit per clock.
// Optional EXACT (perfect-square) output enabled by defining SQRT_EXACT_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for start
// ITER  | retiring one root bit per cycle, cnt = bit index
// FIX   | final remainder correction, publish Q/R
// DONE  | result held until ack or a new start
module sqrt_iter_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  sqrt_iter_core_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   d_sh;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH+1:0]     w_r;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     q_reg;
  logic [WIDTH:0]       r_reg;
  logic                 rdy_reg;
  logic                 busy_reg;
`ifdef SQRT_EXACT_FLAG_EN
  logic                 exact_reg;
`endif

  logic [WIDTH+1:0]     t;
  logic [WIDTH+1:0]     r_iter;
  logic [WIDTH-1:0]     q_iter;
  logic [WIDTH:0]       r_fix;
  logic                 launch;

  // w_r is a two's-complement value; bit WIDTH+1 is its sign.
  always_comb begin
    t      = {w_r[WIDTH-1:0], d_sh[2*WIDTH-1 -: 2]};
    r_iter = w_r[WIDTH+1] ? (t + {w_q, 2'b11}) : (t - {w_q, 2'b01});
    q_iter = {w_q[WIDTH-2:0], ~r_iter[WIDTH+1]};
    r_fix  = w_r[WIDTH:0] + (w_r[WIDTH+1] ? {w_q, 1'b1} : {(WIDTH+1){1'b0}});
    launch = bus.start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_sh      <= '0;
      w_q       <= '0;
      w_r       <= '0;
      cnt       <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      rdy_reg   <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef SQRT_EXACT_FLAG_EN
      exact_reg <= 1'b0;
`endif
    end else if (bus.clr) begin
      state     <= IDLE;
      q_reg     <= '0;
      r_reg     <= '0;
      rdy_reg   <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef SQRT_EXACT_FLAG_EN
      exact_reg <= 1'b0;
`endif
    end else if (launch) begin
      // start wins over ack when both arrive in DONE
      d_sh     <= bus.D;
      w_q      <= '0;
      w_r      <= '0;
      cnt      <= CW'(WIDTH - 1);
      rdy_reg  <= 1'b0;
      busy_reg <= 1'b1;
      state    <= ITER;
    end else begin
      case (state)
        ITER: begin
          d_sh <= d_sh << 2;
          w_r  <= r_iter;
          w_q  <= q_iter;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          q_reg     <= w_q;
          r_reg     <= r_fix;
          rdy_reg   <= 1'b1;
          busy_reg  <= 1'b0;
`ifdef SQRT_EXACT_FLAG_EN
          exact_reg <= (r_fix == '0);
`endif
          state     <= DONE;
        end
        DONE: begin
          if (bus.ack) begin
            rdy_reg <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.RDY  = rdy_reg;
  assign bus.BUSY = busy_reg;
`ifdef SQRT_EXACT_FLAG_EN
  assign bus.EXACT = exact_reg;
`endif

endmodule

// File: tb/tb_sqrt_iter_core.sv
// Self-checking bench for sqrt_iter_core: directed plan plus randomized traffic
// compared every cycle against a transaction-level square-root model.
module tb_sqrt_iter_core;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sqrt_iter_core_if #(.WIDTH(WIDTH)) bus ();

  sqrt_iter_core #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint isqrt(input longint d);
    longint q = 0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      longint c = q | (longint'(1) << b);
      if (c * c <= d) q = c;
    end
    return q;
  endfunction

  // Model: a run lasts WIDTH+1 edges from the start edge, then the result appears.
  longint m_d = 0, m_q = 0, m_r = 0;
  bit     m_rdy = 0, m_busy = 0;
  int     m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = 0; m_r = 0; m_rdy = 0; m_busy = 0; m_left = 0;
    end else if (bus.clr) begin
      m_q = 0; m_r = 0; m_rdy = 0; m_busy = 0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_rdy  = 1;
        m_q    = isqrt(m_d);
        m_r    = m_d - m_q * m_q;
      end
    end else if (bus.start) begin
      m_d    = longint'(bus.D);
      m_busy = 1;
      m_rdy  = 0;
      m_left = WIDTH + 1;
    end else if (m_rdy && bus.ack) begin
      m_rdy = 0;
    end
  end

  always @(negedge clk) begin
    chk("cyc_Q", longint'(bus.Q), m_q);
    chk("cyc_R", longint'(bus.R), m_r);
    chk("cyc_RDY", longint'(bus.RDY), longint'(m_rdy));
    chk("cyc_BUSY", longint'(bus.BUSY), longint'(m_busy));
`ifdef SQRT_EXACT_FLAG_EN
    chk("cyc_EXACT", longint'(bus.EXACT), longint'(m_rdy || m_q != 0 || m_r != 0 ? (m_r == 0 && (m_q != 0 || m_rdy || m_busy)) : 0));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2*WIDTH-1:0] d, output int lat, output int busy_cyc);
    bus.D = d;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cyc = bus.BUSY ? 1 : 0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (bus.BUSY) busy_cyc++;
      if (bus.RDY) break;
    end
    if (!bus.RDY) chk("rdy_timeout", 0, 1);
  endtask

  logic [2*WIDTH-1:0] rd;
  int lat, bc;

  initial begin
    bus.clr = 1'b0; bus.start = 1'b0; bus.ack = 1'b0; bus.D = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    chk("reset_Q", longint'(bus.Q), 0);
    chk("reset_RDY", longint'(bus.RDY), 0);

    // D=0: latency, result, ack
    run(0, lat, bc);
    chk("zero_latency", lat, 17);
    chk("zero_Q", longint'(bus.Q), 0);
    chk("zero_R", longint'(bus.R), 0);
`ifdef SQRT_EXACT_FLAG_EN
    chk("zero_EXACT", longint'(bus.EXACT), 1);
`endif
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("ack_RDY", longint'(bus.RDY), 0);
    tick();
    chk("ack_idle_BUSY", longint'(bus.BUSY), 0);

    run(144, lat, bc);
    chk("d144_Q", longint'(bus.Q), 12);
    chk("d144_R", longint'(bus.R), 0);
    chk("d144_busy_cycles", bc, 17);
    run(150, lat, bc);
    chk("d150_Q", longint'(bus.Q), 12);
    chk("d150_R", longint'(bus.R), 6);
    chk("d150_busy_cycles", bc, 17);
`ifdef SQRT_EXACT_FLAG_EN
    chk("d150_EXACT", longint'(bus.EXACT), 0);
`endif

    run(32'hFFFF_FFFF, lat, bc);
    chk("max_Q", longint'(bus.Q), 65535);
    chk("max_R", longint'(bus.R), 131070);

    // rst mid-ITER aborts at once
    bus.D = 1000; bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_Q", longint'(bus.Q), 0);
    chk("rst_R", longint'(bus.R), 0);
    chk("rst_RDY", longint'(bus.RDY), 0);
    chk("rst_BUSY", longint'(bus.BUSY), 0);
    @(negedge clk);
    rst = 1'b0;
    run(144, lat, bc);
    chk("post_rst_Q", longint'(bus.Q), 12);
    chk("post_rst_R", longint'(bus.R), 0);

    // start while busy is ignored; start+ack in DONE relaunches
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    bus.D = 100; bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (4) tick();
    bus.D = 49; bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < 30 && !bus.RDY; i++) tick();
    chk("busy_start_Q", longint'(bus.Q), 10);
    chk("busy_start_R", longint'(bus.R), 0);
    bus.D = 49; bus.start = 1'b1; bus.ack = 1'b1; tick();
    bus.start = 1'b0; bus.ack = 1'b0;
    chk("relaunch_BUSY", longint'(bus.BUSY), 1);
    chk("relaunch_RDY", longint'(bus.RDY), 0);
    for (int i = 0; i < 30 && !bus.RDY; i++) tick();
    chk("relaunch_Q", longint'(bus.Q), 7);
    chk("relaunch_R", longint'(bus.R), 0);

    // clr with start in the same cycle
    bus.D = 150; bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (7) tick();
    bus.clr = 1'b1; bus.start = 1'b1; tick();
    bus.clr = 1'b0; bus.start = 1'b0;
    chk("clr_Q", longint'(bus.Q), 0);
    chk("clr_R", longint'(bus.R), 0);
    chk("clr_RDY", longint'(bus.RDY), 0);
    chk("clr_BUSY", longint'(bus.BUSY), 0);
    repeat (20) tick();
    chk("clr_no_run_RDY", longint'(bus.RDY), 0);

    // randomized traffic, biased toward perfect squares and their neighbours
    for (int c = 0; c < 4000; c++) begin
      int k;
      k = $urandom_range(0, 65535);
      case ($urandom_range(0, 3))
        0: rd = 32'(k * k);
        1: rd = (k > 0) ? 32'(k * k - 1) : 32'd0;
        2: rd = 32'(k * k + 2 * k);
        default: rd = $urandom;
      endcase
      bus.D     = rd;
      bus.start = ($urandom_range(0, 9) == 0);
      bus.ack   = ($urandom_range(0, 3) == 0);
      bus.clr   = ($urandom_range(0, 149) == 0);
      tick();
    end
    bus.start = 1'b0; bus.ack = 1'b0; bus.clr = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
